// File: rtl/ps2_key_ctrl_if.sv
// Port bundle of ps2_key_ctrl: keyboard FIFO pop side, key-event stream, status and debug taps.
// The DUT uses the master modport; the environment (FIFO model, consumer) uses slave.
interface ps2_key_ctrl_if #(
    parameter int CNT_W = 16
);
    logic [7:0]       kbd_data;
    logic             kbd_ready;
    logic             kbd_nextdata_n;

    // Event handshake: ev_valid rises only when an event is complete, and
    // every ev_* field holds steady until a cycle in which ev_valid and
    // ev_ready are both high; that cycle transfers the event. ev_valid never
    // waits for ev_ready.
    logic             ev_valid;
    logic             ev_ready;
    logic [7:0]       ev_code;
    logic             ev_ext;
    logic             ev_release;
    logic             ev_repeat;
    logic [7:0]       ev_ascii;

    logic [CNT_W-1:0] press_cnt;
    logic             shift_held;

    logic [1:0]       dbg_state;
    logic             dbg_hold_v;

    modport master (
        input  kbd_data, kbd_ready, ev_ready,
        output kbd_nextdata_n, ev_valid, ev_code, ev_ext, ev_release,
               ev_repeat, ev_ascii, press_cnt, shift_held, dbg_state, dbg_hold_v
    );

    modport slave (
        output kbd_data, kbd_ready, ev_ready,
        input  kbd_nextdata_n, ev_valid, ev_code, ev_ext, ev_release,
               ev_repeat, ev_ascii, press_cnt, shift_held, dbg_state, dbg_hold_v
    );
endinterface

// File: rtl/ps2_key_ctrl.sv
// Pops PS/2 set-2 bytes from the keyboard FIFO, folds E0/F0 prefixes into key events,
// tracks Shift and the held key for typematic/ASCII, and presents events on valid/ready.
module ps2_key_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic           clk,
    input  logic           clrn,
    ps2_key_ctrl_if.master bus
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FETCH  = 2'd1,
        DECODE = 2'd2,
        EMIT   = 2'd3
    } state_t;

    state_t           state, state_nxt;
    logic [7:0]       byte_r;
    logic             brk_f, ext_f;
    logic             hold_v, hold_ext;
    logic [7:0]       hold_code;
    logic             shift_l, shift_r;
    logic [CNT_W-1:0] cnt_r;
    logic [7:0]       code_r, ascii_r;
    logic             ext_r, rel_r, rep_r;

    logic             is_prefix, is_make, hold_match;
    logic             shift_l_nxt, shift_r_nxt;
    logic [7:0]       ascii_nxt;

    function automatic logic [7:0] to_ascii(input logic [7:0] c, input logic up);
        logic [7:0] a;
        a = 8'h00;
        case (c)
            8'h1C: a = 8'h61;  8'h32: a = 8'h62;  8'h21: a = 8'h63;  8'h23: a = 8'h64;
            8'h24: a = 8'h65;  8'h2B: a = 8'h66;  8'h34: a = 8'h67;  8'h33: a = 8'h68;
            8'h43: a = 8'h69;  8'h3B: a = 8'h6A;  8'h42: a = 8'h6B;  8'h4B: a = 8'h6C;
            8'h3A: a = 8'h6D;  8'h31: a = 8'h6E;  8'h44: a = 8'h6F;  8'h4D: a = 8'h70;
            8'h15: a = 8'h71;  8'h2D: a = 8'h72;  8'h1B: a = 8'h73;  8'h2C: a = 8'h74;
            8'h3C: a = 8'h75;  8'h2A: a = 8'h76;  8'h1D: a = 8'h77;  8'h22: a = 8'h78;
            8'h35: a = 8'h79;  8'h1A: a = 8'h7A;
            8'h45: a = 8'h30;  8'h16: a = 8'h31;  8'h1E: a = 8'h32;  8'h26: a = 8'h33;
            8'h25: a = 8'h34;  8'h2E: a = 8'h35;  8'h36: a = 8'h36;  8'h3D: a = 8'h37;
            8'h3E: a = 8'h38;  8'h46: a = 8'h39;
            8'h29: a = 8'h20;  8'h5A: a = 8'h0D;  8'h66: a = 8'h08;
            default: a = 8'h00;
        endcase
        if (up && (a >= 8'h61) && (a <= 8'h7A)) begin
            a = a - 8'h20;
        end
        return a;
    endfunction

    always_ff @(posedge clk or posedge clrn) begin
        if (clrn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.kbd_ready) state_nxt = FETCH;
            FETCH:   state_nxt = DECODE;
            DECODE:  state_nxt = is_prefix ? IDLE : EMIT;
            EMIT:    if (bus.ev_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.kbd_nextdata_n = 1'b1;
        bus.ev_valid       = 1'b0;
        case (state)
            FETCH:   bus.kbd_nextdata_n = 1'b0;
            EMIT:    bus.ev_valid       = 1'b1;
            default: ;
        endcase
    end

    // Shift state as it stands after the byte in byte_r, so a Shift make
    // and the letter it modifies can arrive back to back.
    always_comb begin
        is_prefix   = (byte_r == 8'hF0) || (byte_r == 8'hE0);
        is_make     = ~brk_f;
        hold_match  = hold_v && (hold_ext == ext_f) && (hold_code == byte_r);
        shift_l_nxt = shift_l;
        shift_r_nxt = shift_r;
        if (!ext_f && byte_r == 8'h12) shift_l_nxt = is_make;
        if (!ext_f && byte_r == 8'h59) shift_r_nxt = is_make;
        ascii_nxt = (ext_f || brk_f) ? 8'h00 : to_ascii(byte_r, shift_l_nxt | shift_r_nxt);
    end

    always_ff @(posedge clk or posedge clrn) begin
        if (clrn) begin
            byte_r    <= 8'h00;
            brk_f     <= 1'b0;
            ext_f     <= 1'b0;
            hold_v    <= 1'b0;
            hold_ext  <= 1'b0;
            hold_code <= 8'h00;
            shift_l   <= 1'b0;
            shift_r   <= 1'b0;
            cnt_r     <= '0;
            code_r    <= 8'h00;
            ascii_r   <= 8'h00;
            ext_r     <= 1'b0;
            rel_r     <= 1'b0;
            rep_r     <= 1'b0;
        end else begin
            if (state == FETCH) begin
                byte_r <= bus.kbd_data;
            end
            if (state == DECODE) begin
                if (byte_r == 8'hF0) begin
                    brk_f <= 1'b1;
                end else if (byte_r == 8'hE0) begin
                    ext_f <= 1'b1;
                end else begin
                    code_r  <= byte_r;
                    ext_r   <= ext_f;
                    rel_r   <= brk_f;
                    rep_r   <= is_make && hold_match;
                    ascii_r <= ascii_nxt;
                    brk_f   <= 1'b0;
                    ext_f   <= 1'b0;
                    shift_l <= shift_l_nxt;
                    shift_r <= shift_r_nxt;
                    if (is_make) begin
                        if (!hold_match) begin
                            cnt_r     <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                            hold_v    <= 1'b1;
                            hold_ext  <= ext_f;
                            hold_code <= byte_r;
                        end
                    end else if (hold_match) begin
                        hold_v <= 1'b0;
                    end
                end
            end
        end
    end

    assign bus.ev_code    = code_r;
    assign bus.ev_ext     = ext_r;
    assign bus.ev_release = rel_r;
    assign bus.ev_repeat  = rep_r;
    assign bus.ev_ascii   = ascii_r;
    assign bus.press_cnt  = cnt_r;
    assign bus.shift_held = shift_l | shift_r;
    assign bus.dbg_state  = state;
    assign bus.dbg_hold_v = hold_v;
endmodule

// File: tb/tb_ps2_key_ctrl.sv
// Directed bench for ps2_key_ctrl: a FIFO model feeds two lockstep instances
// (16-bit and 4-bit counters) and every expected value is hand-derived.
module tb_ps2_key_ctrl;
    logic clk = 1'b0;
    logic clrn = 1'b1;
    logic ev_ready = 1'b0;

    always #5 clk = ~clk;

    ps2_key_ctrl_if #(.CNT_W(16)) bus();
    ps2_key_ctrl_if #(.CNT_W(4))  bus4();

    ps2_key_ctrl #(.CNT_W(16)) dut  (.clk(clk), .clrn(clrn), .bus(bus));
    ps2_key_ctrl #(.CNT_W(4))  dut4 (.clk(clk), .clrn(clrn), .bus(bus4));

    logic [7:0] fifo_mem [256];
    int wr_ptr = 0;
    int rd_ptr = 0;
    int pulses = 0;
    int dbl = 0;
    int lockstep = 0;
    bit pop_pending = 1'b0;
    bit prev_low = 1'b0;

    int checks = 0;
    int errors = 0;

    assign bus.kbd_data   = fifo_mem[8'(rd_ptr)];
    assign bus.kbd_ready  = (rd_ptr != wr_ptr);
    assign bus.ev_ready   = ev_ready;
    assign bus4.kbd_data  = bus.kbd_data;
    assign bus4.kbd_ready = bus.kbd_ready;
    assign bus4.ev_ready  = ev_ready;

    // Sample the pop strobe just before each rising edge; the FIFO advances on that edge.
    always @(negedge clk) begin
        #4;
        pop_pending = !bus.kbd_nextdata_n && (rd_ptr != wr_ptr);
        if (!bus.kbd_nextdata_n) begin
            pulses++;
            if (prev_low) dbl++;
        end
        prev_low = !bus.kbd_nextdata_n;
        if (bus.kbd_nextdata_n !== bus4.kbd_nextdata_n || bus.ev_valid !== bus4.ev_valid)
            lockstep++;
    end

    always @(posedge clk) begin
        if (pop_pending) rd_ptr <= rd_ptr + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [7:0] b);
        fifo_mem[8'(wr_ptr)] = b;
        wr_ptr++;
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        while (bus.ev_valid !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check({tag, " valid"}, 32'(bus.ev_valid), 32'd1);
    endtask

    task automatic get_ev(input string tag, input logic [7:0] code, input logic ext,
                          input logic rel, input logic rep, input logic [7:0] asc,
                          input int cnt);
        wait_valid(tag);
        check({tag, " code"},    32'(bus.ev_code),    32'(code));
        check({tag, " ext"},     32'(bus.ev_ext),     32'(ext));
        check({tag, " release"}, 32'(bus.ev_release), 32'(rel));
        check({tag, " repeat"},  32'(bus.ev_repeat),  32'(rep));
        check({tag, " ascii"},   32'(bus.ev_ascii),   32'(asc));
        check({tag, " cnt"},     32'(bus.press_cnt),  32'(cnt));
        check({tag, " cnt4"},    32'(bus4.press_cnt), 32'(cnt % 16));
        ev_ready = 1'b1;
        @(negedge clk);
        ev_ready = 1'b0;
        check({tag, " drop"}, 32'(bus.ev_valid), 32'd0);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, " state"},   32'(bus.dbg_state),      32'd0);
        check({tag, " pop_n"},   32'(bus.kbd_nextdata_n), 32'd1);
        check({tag, " valid"},   32'(bus.ev_valid),       32'd0);
        check({tag, " code"},    32'(bus.ev_code),        32'd0);
        check({tag, " flags"},   32'({bus.ev_ext, bus.ev_release, bus.ev_repeat}), 32'd0);
        check({tag, " ascii"},   32'(bus.ev_ascii),       32'd0);
        check({tag, " cnt"},     32'(bus.press_cnt),      32'd0);
        check({tag, " shift"},   32'(bus.shift_held),     32'd0);
        check({tag, " hold_v"},  32'(bus.dbg_hold_v),     32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int seen;
        int p0;
        int stall_bad;
        logic [7:0] codes [17];

        repeat (2) @(negedge clk);
        check_reset_vals("reset");
        clrn = 1'b0;
        @(negedge clk);

        // Plain make then break of 'a', with latency of the first event.
        push(8'h1C);
        @(negedge clk);
        check("lat fetch pop_n", 32'(bus.kbd_nextdata_n), 32'd0);
        @(negedge clk);
        check("lat decode valid", 32'(bus.ev_valid), 32'd0);
        check("lat decode pop_n", 32'(bus.kbd_nextdata_n), 32'd1);
        @(negedge clk);
        check("lat emit valid", 32'(bus.ev_valid), 32'd1);
        get_ev("a make", 8'h1C, 1'b0, 1'b0, 1'b0, 8'h61, 1);
        push(8'hF0); push(8'h1C);
        get_ev("a break", 8'h1C, 1'b0, 1'b1, 1'b0, 8'h00, 1);
        check("a pulses", 32'(pulses), 32'd3);

        // Shift + letter, typematic repeat, releases.
        push(8'h12); push(8'h1C); push(8'h1C); push(8'hF0); push(8'h1C); push(8'hF0); push(8'h12);
        get_ev("lshift make", 8'h12, 1'b0, 1'b0, 1'b0, 8'h00, 2);
        check("lshift held", 32'(bus.shift_held), 32'd1);
        get_ev("A make", 8'h1C, 1'b0, 1'b0, 1'b0, 8'h41, 3);
        get_ev("A repeat", 8'h1C, 1'b0, 1'b0, 1'b1, 8'h41, 3);
        get_ev("A break", 8'h1C, 1'b0, 1'b1, 1'b0, 8'h00, 3);
        get_ev("lshift break", 8'h12, 1'b0, 1'b1, 1'b0, 8'h00, 3);
        check("lshift released", 32'(bus.shift_held), 32'd0);

        // Extended make/break and a doubled break prefix.
        push(8'hE0); push(8'h75); push(8'hE0); push(8'hF0); push(8'h75);
        get_ev("ext make", 8'h75, 1'b1, 1'b0, 1'b0, 8'h00, 4);
        check("ext hold set", 32'(bus.dbg_hold_v), 32'd1);
        get_ev("ext break", 8'h75, 1'b1, 1'b1, 1'b0, 8'h00, 4);
        check("ext hold clear", 32'(bus.dbg_hold_v), 32'd0);
        push(8'hF0); push(8'hF0); push(8'h2A);
        get_ev("dbl F0", 8'h2A, 1'b0, 1'b1, 1'b0, 8'h00, 4);

        // Back-pressure with three bytes queued.
        push(8'h1C); push(8'h32); push(8'h21);
        wait_valid("stall first");
        p0 = pulses;
        stall_bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.ev_valid !== 1'b1 || bus.ev_code !== 8'h1C || bus.ev_ascii !== 8'h61)
                stall_bad++;
        end
        check("stall outputs stable", 32'(stall_bad), 32'd0);
        check("stall no pop", 32'(pulses), 32'(p0));
        get_ev("drain a", 8'h1C, 1'b0, 1'b0, 1'b0, 8'h61, 5);
        get_ev("drain b", 8'h32, 1'b0, 1'b0, 1'b0, 8'h62, 6);
        get_ev("drain c", 8'h21, 1'b0, 1'b0, 1'b0, 8'h63, 7);

        // Reset during FETCH of the code byte after an F0 prefix.
        push(8'hF0); push(8'h1C);
        n = 0;
        seen = 0;
        while (seen < 2 && n < 40) begin
            @(negedge clk);
            n++;
            if (bus.dbg_state == 2'd1) seen++;
        end
        check("fetch reached", 32'(seen), 32'd2);
        #2 clrn = 1'b1;
        #1 check_reset_vals("rst fetch");
        @(negedge clk);
        check("rst fetch hold state", 32'(bus.dbg_state), 32'd0);
        clrn = 1'b0;
        get_ev("after fetch rst", 8'h1C, 1'b0, 1'b0, 1'b0, 8'h61, 1);

        // Reset during EMIT.
        push(8'h66);
        wait_valid("bs");
        check("bs ascii", 32'(bus.ev_ascii), 32'h08);
        check("bs cnt", 32'(bus.press_cnt), 32'd2);
        #2 clrn = 1'b1;
        #1 check_reset_vals("rst emit");
        @(negedge clk);
        check("rst emit valid", 32'(bus.ev_valid), 32'd0);
        clrn = 1'b0;
        push(8'h29);
        get_ev("space", 8'h29, 1'b0, 1'b0, 1'b0, 8'h20, 1);
        push(8'h5A);
        get_ev("enter", 8'h5A, 1'b0, 1'b0, 1'b0, 8'h0D, 2);

        // Right Shift, uppercase letter, digits with and without Shift.
        push(8'h59); push(8'h35); push(8'hF0); push(8'h59); push(8'h45);
        get_ev("rshift make", 8'h59, 1'b0, 1'b0, 1'b0, 8'h00, 3);
        check("rshift held", 32'(bus.shift_held), 32'd1);
        get_ev("Y make", 8'h35, 1'b0, 1'b0, 1'b0, 8'h59, 4);
        get_ev("rshift break", 8'h59, 1'b0, 1'b1, 1'b0, 8'h00, 4);
        check("rshift released", 32'(bus.shift_held), 32'd0);
        get_ev("digit 0", 8'h45, 1'b0, 1'b0, 1'b0, 8'h30, 5);
        push(8'h12); push(8'h16); push(8'hF0); push(8'h12);
        get_ev("shift again", 8'h12, 1'b0, 1'b0, 1'b0, 8'h00, 6);
        get_ev("digit 1 shifted", 8'h16, 1'b0, 1'b0, 1'b0, 8'h31, 7);
        get_ev("shift off", 8'h12, 1'b0, 1'b1, 1'b0, 8'h00, 7);

        // 17 distinct makes from reset: 4-bit counter wraps to 1.
        #2 clrn = 1'b1;
        @(negedge clk);
        clrn = 1'b0;
        codes = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43,
                  8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15};
        for (int i = 0; i < 17; i++) begin
            push(codes[i]);
            get_ev("wrap", codes[i], 1'b0, 1'b0, 1'b0, 8'(8'h61 + i), i + 1);
        end
        check("wrap cnt4 final", 32'(bus4.press_cnt), 32'd1);
        check("wrap cnt16 final", 32'(bus.press_cnt), 32'd17);

        repeat (4) @(negedge clk);
        check("no double strobe", 32'(dbl), 32'd0);
        check("instances lockstep", 32'(lockstep), 32'd0);
        check("pulses per byte", 32'(pulses), 32'(wr_ptr));
        check("fifo drained", 32'(rd_ptr), 32'(wr_ptr));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/ps2_key_ctrl.md
# ps2_key_ctrl

Sequencer that sits between `ps2_keyboard`'s scan-code FIFO and the rest of the NPC. It pops bytes with the `ready`/`nextdata_n` handshake and assembles PS/2 set-2 prefixes (E0 extended, F0 break) into single key events. It tracks Shift and the currently held key so it can flag typematic repeats and translate to ASCII. Each event is delivered on a valid/ready port together with a running key-press counter.

## Interface
Parameters:
- `CNT_W`, default 16: width of the key-press counter.

Ports:
- `clk`  in  1  system clock; everything is on its rising edge.
- `clrn`  in  1  reset; asynchronous, active-high (despite the name).
- `kbd_data`  in  8  byte at the keyboard FIFO head.
- `kbd_ready`  in  1  FIFO non-empty.
- `kbd_nextdata_n`  out  1  active-low pop strobe to the keyboard.
- `ev_valid`  out  1  event available.
- `ev_ready`  in  1  consumer accepts the event.
- `ev_code`  out  8  scan code with prefixes stripped.
- `ev_ext`  out  1  code was preceded by E0.
- `ev_release`  out  1  break event (code was preceded by F0).
- `ev_repeat`  out  1  make event for a key that is already held (typematic).
- `ev_ascii`  out  8  ASCII value, or 0x00 when the key has no mapping.
- `press_cnt`  out  CNT_W  number of non-repeat make events; wraps modulo 2^CNT_W.
- `shift_held`  out  1  left (0x12) or right (0x59) Shift is down.

## Operation
- FSM states: IDLE, FETCH, DECODE, EMIT.
- **IDLE**
  - `kbd_ready=1`: go to FETCH.
  - Otherwise stay in IDLE.
- **FETCH** (exactly 1 cycle)
  - `kbd_nextdata_n` is combinationally `~(state==FETCH)`.
  - `kbd_data` is captured into `byte_r` on the same edge at which the keyboard advances its read pointer.
  - Go to DECODE.
- **DECODE** (1 cycle)
  - `byte_r==F0`: set `brk_f`, go to IDLE.
  - `byte_r==E0`: set `ext_f`, go to IDLE.
  - Any other byte forms an event:
    - `ev_code=byte_r`, `ev_ext=ext_f`, `ev_release=brk_f`.
    - Clear `brk_f` and `ext_f`.
    - Update held-key and Shift state, as below.
    - Go to EMIT.
- **EMIT**
  - `ev_valid=1`; all `ev_*` outputs are stable until handshake.
  - On `ev_valid & ev_ready`: go to IDLE.
  - No FIFO pop occurs while in EMIT, so back-pressure reaches the keyboard FIFO.
- **Held-key tracking** (registers `hold_v`, `hold_code`, `hold_ext`):
  - Make event with `hold_v` set and `{ext,code}=={hold_ext,hold_code}`: `ev_repeat=1`, counter unchanged.
  - Any other make event: `ev_repeat=0`, `press_cnt+1`, hold registers load `{1,ext,code}`.
  - Break event matching the hold registers: clear `hold_v`.
  - Breaks never set `ev_repeat`.
- **Shift**
  - Non-extended 0x12/0x59 make sets the corresponding bit; break clears it.
  - `shift_held` is the OR of the two bits.
  - Shift events are still emitted and still counted.
- **ASCII** (non-extended, non-release only; everything else gives 0x00):
  - Letters: 1C A, 32 B, 21 C, 23 D, 24 E, 2B F, 34 G, 33 H, 43 I, 3B J, 42 K, 4B L, 3A M, 31 N, 44 O, 4D P, 15 Q, 2D R, 1B S, 2C T, 3C U, 2A V, 1D W, 22 X, 35 Y, 1A Z.
  - Letters are uppercase when `shift_held` (value at DECODE, after updating for this event) else lowercase.
  - Digits: 45 '0', 16 '1', 1E '2', 26 '3', 25 '4', 2E '5', 36 '6', 3D '7', 3E '8', 46 '9'; Shift does not alter them.
  - Other keys: 29 → 0x20, 5A → 0x0D, 66 → 0x08.
- **Prefix rules**
  - Both prefixes may precede a code: E0 F0 xx gives `ext=1, release=1`.
  - A repeated prefix is idempotent.

## Timing
- Reset values:
  - State IDLE.
  - `kbd_nextdata_n=1`, `ev_valid=0`.
  - All `ev_*` outputs 0.
  - `press_cnt=0`, `shift_held=0`.
  - `hold_v`, `brk_f`, `ext_f` all 0.
- Reset asserted mid-operation (any state) returns to IDLE immediately.
  - A byte already popped is discarded; no partial event is emitted.
- Latency:
  - Prefix byte: 3 cycles, IDLE→FETCH→DECODE→IDLE.
  - Code byte: `kbd_ready` seen in IDLE at cycle n gives `ev_valid=1` at cycle n+3.
  - Minimum 4 cycles per event when `ev_ready` is tied high.
- Strobe rule: `kbd_nextdata_n` is low for exactly one cycle per byte, never two consecutive cycles.
  - This guarantees one pop per FETCH, even when `kbd_ready` stays high because the FIFO is not empty.
- `press_cnt` and `shift_held` update on the DECODE→EMIT edge.
  - Both are visible in the first EMIT cycle.

## Test plan
- Model the FIFO with bytes 1C, F0, 1C, `ev_ready=1` → two events:
  - {code 1C, rel 0, ascii 0x61}, then {code 1C, rel 1, ascii 0x00}.
  - `press_cnt=1`; exactly 3 `kbd_nextdata_n` pulses.
- Bytes 12, 1C, 1C, F0 1C, F0 12 →
  - ascii 0x41 on both 1C makes; second 1C has `ev_repeat=1`.
  - `press_cnt=2`; `shift_held` returns to 0 after the final event.
- Bytes E0, 75, E0, F0, 75 →
  - {75, ext 1, rel 0, ascii 0} and {75, ext 1, rel 1}.
  - `hold_v` cleared at the end.
- Back-pressure: hold `ev_ready=0` for 20 cycles with 3 bytes queued →
  - `ev_valid` held, outputs stable, no `kbd_nextdata_n` pulse during the stall.
  - Events drain in order after release.
- Assert `clrn` in FETCH and again in EMIT → next cycle:
  - all outputs at reset values, state IDLE.
  - the following event is decoded cleanly (no stale F0/E0 flags).
- CNT_W=4 with 17 distinct makes → `press_cnt` wraps to 1.
